// File: rtl/dtw_sdtw_engine_if.sv
// Handshake and control bundle for one subsequence-DTW engine channel.
// The master side is the job controller, and the slave side is the engine.
interface dtw_sdtw_engine_if #(
    parameter int WIDTH  = 16,
    parameter int COST_W = 24,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  qry_len;
    logic [31:0]       ref_len;
    logic [COST_W-1:0] thresh;
    logic              abort;
    logic              sq_valid;
    logic [WIDTH-1:0]  sq_data;
    logic              sq_ready;
    logic              ref_valid;
    logic [WIDTH-1:0]  ref_data;
    logic              ref_ready;
    logic              busy;
    logic              res_valid;
    logic [COST_W-1:0] minval;
    logic [31:0]       position;
    logic              hit;
    logic              err;

    modport master (
        output start, qry_len, ref_len, thresh, abort,
        output sq_valid, sq_data, ref_valid, ref_data,
        input  sq_ready, ref_ready, busy, res_valid, minval, position, hit, err
    );

    modport slave (
        input  start, qry_len, ref_len, thresh, abort,
        input  sq_valid, sq_data, ref_valid, ref_data,
        output sq_ready, ref_ready, busy, res_valid, minval, position, hit, err
    );
endinterface

// File: rtl/dtw_sdtw_engine.sv
// Systolic subsequence-DTW engine. PE k holds q[k+1] and computes row k+1.
// Reference samples ripple down the array one PE per advance step.
module dtw_sdtw_engine #(
    parameter int WIDTH    = 16,
    parameter int COST_W   = 24,
    parameter int SQG_SIZE = 250,
    parameter int LEN_W    = 8
) (
    input logic             clk,
    input logic             rst,
    dtw_sdtw_engine_if.slave bus
);
    localparam logic [COST_W-1:0] INF    = {COST_W{1'b1}};
    localparam logic [COST_W-1:0] ZERO_C = {COST_W{1'b0}};
    localparam logic [LEN_W-1:0]  ZERO_L = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  ONE_L  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  MAX_L  = LEN_W'(SQG_SIZE);
    localparam logic [WIDTH-1:0]  ZERO_W = {WIDTH{1'b0}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Q = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                  input logic [COST_W-1:0] b);
        logic [COST_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, INF}) return INF;
        else return s[COST_W-1:0];
    endfunction

    function automatic logic [COST_W-1:0] min3(input logic [COST_W-1:0] a,
                                               input logic [COST_W-1:0] b,
                                               input logic [COST_W-1:0] c);
        logic [COST_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COST_W-1:0] abs_cost(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        if (a >= b) d = a - b;
        else d = b - a;
        return COST_W'(d);
    endfunction

    logic [2:0]        state_r;
    logic [LEN_W-1:0]  qlen_r;
    logic [31:0]       nlen_r;
    logic [COST_W-1:0] thr_r;
    logic [LEN_W-1:0]  ld_cnt_r;
    logic [31:0]       in_cnt_r;
    logic [31:0]       out_cnt_r;
    logic [COST_W-1:0] minval_r;
    logic [31:0]       pos_r;
    logic              hit_r;
    logic              err_r;

    logic [WIDTH-1:0]  q_r   [SQG_SIZE];
    logic [COST_W-1:0] d_r   [SQG_SIZE];
    logic [COST_W-1:0] dp_r  [SQG_SIZE];
    logic              v_r   [SQG_SIZE];
    logic [WIDTH-1:0]  rr_r  [SQG_SIZE];

    logic              tok_v_s [SQG_SIZE];
    logic [WIDTH-1:0]  tok_r_s [SQG_SIZE];
    logic [COST_W-1:0] nd_s    [SQG_SIZE];

    logic              start_acc_s;
    logic              len_bad_s;
    logic              ref_acc_s;
    logic              sq_acc_s;
    logic              step_s;
    logic [LEN_W-1:0]  sel_idx_s;
    logic              sel_v_s;
    logic [COST_W-1:0] sel_d_s;

    assign start_acc_s = (state_r == S_IDLE) && bus.start && !bus.abort;
    assign len_bad_s   = (bus.qry_len == ZERO_L) || (bus.qry_len > MAX_L);
    assign sq_acc_s    = (state_r == S_LOAD_Q) && bus.sq_valid;
    assign ref_acc_s   = (state_r == S_RUN) && bus.ref_valid;
    assign step_s      = ref_acc_s || (state_r == S_DRAIN);
    assign sel_idx_s   = qlen_r - ONE_L;

    // PE datapath: incoming token, neighbour costs and the new cell value per row.
    always_comb begin
        for (int k = 0; k < SQG_SIZE; k++) begin
            tok_v_s[k] = 1'b0;
            tok_r_s[k] = ZERO_W;
            nd_s[k]    = INF;
            if (k == 0) begin
                tok_v_s[k] = ref_acc_s;
                tok_r_s[k] = bus.ref_data;
                nd_s[k]    = sat_add(abs_cost(q_r[k], tok_r_s[k]),
                                     min3(ZERO_C, d_r[k], ZERO_C));
            end else begin
                tok_v_s[k] = v_r[k-1];
                tok_r_s[k] = rr_r[k-1];
                nd_s[k]    = sat_add(abs_cost(q_r[k], tok_r_s[k]),
                                     min3(d_r[k-1], d_r[k], dp_r[k-1]));
            end
        end
    end

    // Pick row L out of the array for min tracking.
    always_comb begin
        sel_v_s = 1'b0;
        sel_d_s = INF;
        for (int k = 0; k < SQG_SIZE; k++) begin
            sel_v_s = sel_v_s | ((LEN_W'(k) == sel_idx_s) && tok_v_s[k]);
            sel_d_s = (LEN_W'(k) == sel_idx_s) ? nd_s[k] : sel_d_s;
        end
    end

    // Query sample storage, filled in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SQG_SIZE; k++) q_r[k] <= ZERO_W;
        end else if (sq_acc_s) begin
            for (int k = 0; k < SQG_SIZE; k++) begin
                if (LEN_W'(k) == ld_cnt_r) q_r[k] <= bus.sq_data;
            end
        end
    end

    // Wavefront state. Column 0 is +inf, and the whole array freezes when no step is taken.
    always_ff @(posedge clk) begin
        if (rst || start_acc_s) begin
            for (int k = 0; k < SQG_SIZE; k++) begin
                d_r[k]  <= INF;
                dp_r[k] <= INF;
                v_r[k]  <= 1'b0;
                rr_r[k] <= ZERO_W;
            end
        end else if (step_s) begin
            for (int k = 0; k < SQG_SIZE; k++) begin
                v_r[k]  <= tok_v_s[k];
                rr_r[k] <= tok_r_s[k];
                if (tok_v_s[k]) begin
                    dp_r[k] <= d_r[k];
                    d_r[k]  <= nd_s[k];
                end
            end
        end
    end

    // Job control FSM, min/position tracking and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            qlen_r    <= ZERO_L;
            nlen_r    <= 32'd0;
            thr_r     <= ZERO_C;
            ld_cnt_r  <= ZERO_L;
            in_cnt_r  <= 32'd0;
            out_cnt_r <= 32'd0;
            minval_r  <= INF;
            pos_r     <= 32'd0;
            hit_r     <= 1'b0;
            err_r     <= 1'b0;
        end else if (bus.abort && (state_r != S_IDLE)) begin
            state_r <= S_IDLE;
        end else begin
            if (step_s && sel_v_s) begin
                out_cnt_r <= out_cnt_r + 32'd1;
                if (sel_d_s < minval_r) begin
                    minval_r <= sel_d_s;
                    pos_r    <= out_cnt_r + 32'd1;
                end
            end
            case (state_r)
                S_IDLE: begin
                    if (start_acc_s) begin
                        qlen_r    <= bus.qry_len;
                        nlen_r    <= bus.ref_len;
                        thr_r     <= bus.thresh;
                        ld_cnt_r  <= ZERO_L;
                        in_cnt_r  <= 32'd0;
                        out_cnt_r <= 32'd0;
                        minval_r  <= INF;
                        pos_r     <= 32'd0;
                        hit_r     <= 1'b0;
                        err_r     <= len_bad_s;
                        state_r   <= len_bad_s ? S_DONE : S_LOAD_Q;
                    end
                end
                S_LOAD_Q: begin
                    if (bus.sq_valid) begin
                        ld_cnt_r <= ld_cnt_r + ONE_L;
                        if (ld_cnt_r == sel_idx_s) begin
                            state_r <= (nlen_r == 32'd0) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.ref_valid) begin
                        in_cnt_r <= in_cnt_r + 32'd1;
                        if (in_cnt_r == nlen_r - 32'd1) state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt_r == nlen_r) begin
                        hit_r   <= (minval_r <= thr_r);
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sq_ready  = (state_r == S_LOAD_Q);
    assign bus.ref_ready = (state_r == S_RUN);
    assign bus.busy      = (state_r != S_IDLE);
    assign bus.res_valid = (state_r == S_DONE);
    assign bus.minval    = minval_r;
    assign bus.position  = pos_r;
    assign bus.hit       = hit_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_dtw_sdtw_engine.sv
// Directed bench for dtw_sdtw_engine. A 24-bit cost instance runs the main jobs.
// A 16-bit cost instance runs the saturation job.
module tb_dtw_sdtw_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtw_sdtw_engine_if #(.WIDTH(16), .COST_W(24), .LEN_W(8)) a_if ();
    dtw_sdtw_engine_if #(.WIDTH(16), .COST_W(16), .LEN_W(8)) b_if ();

    dtw_sdtw_engine #(.WIDTH(16), .COST_W(24), .SQG_SIZE(250), .LEN_W(8)) u_a (
        .clk(clk), .rst(rst), .bus(a_if.slave));
    dtw_sdtw_engine #(.WIDTH(16), .COST_W(16), .SQG_SIZE(250), .LEN_W(8)) u_b (
        .clk(clk), .rst(rst), .bus(b_if.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int pulses_a = 0;
    int rdy_a    = 0;
    // Count result pulses and ready assertions on the main instance.
    always @(negedge clk) begin
        if (a_if.res_valid === 1'b1) pulses_a <= pulses_a + 1;
        if (a_if.sq_ready === 1'b1 || a_if.ref_ready === 1'b1) rdy_a <= rdy_a + 1;
    end

    logic [15:0] qbuf [0:255];
    logic [15:0] rbuf [0:15];
    logic [23:0] r_min;
    logic [31:0] r_pos;
    logic        r_hit, r_err;
    int          r_lat, r_pulses, r_rdy;

    task automatic run_a(input int L, input int N, input logic [23:0] th,
                         input bit gaps, input int abort_at);
        int i;
        int guard;
        int p0;
        int y0;
        bit fire;
        p0 = pulses_a;
        y0 = rdy_a;
        a_if.qry_len = 8'(L);
        a_if.ref_len = 32'(N);
        a_if.thresh  = th;
        a_if.start   = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        i = 0;
        guard = 0;
        while (L >= 1 && L <= 250 && i < L && guard < 2000) begin
            a_if.sq_valid = !(gaps && ($urandom_range(0, 2) == 0));
            a_if.sq_data  = qbuf[i];
            fire = a_if.sq_valid && a_if.sq_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        a_if.sq_valid = 1'b0;
        i = 0;
        while (L >= 1 && L <= 250 && i < N && guard < 2000) begin
            if (i == abort_at) begin
                a_if.abort = 1'b1;
                @(posedge clk); #1;
                a_if.abort = 1'b0;
                break;
            end
            a_if.ref_valid = !(gaps && ($urandom_range(0, 2) == 0));
            a_if.ref_data  = rbuf[i];
            fire = a_if.ref_valid && a_if.ref_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        a_if.ref_valid = 1'b0;
        chk("handshake_bound", 64'(guard < 2000), 64'd1);
        r_lat = 0;
        if (abort_at < 0) begin
            while (a_if.res_valid !== 1'b1 && r_lat < 1000) begin
                @(posedge clk); #1;
                r_lat++;
            end
            chk("result_bound", 64'(r_lat < 1000), 64'd1);
        end
        r_min = a_if.minval;
        r_pos = a_if.position;
        r_hit = a_if.hit;
        r_err = a_if.err;
        repeat (3) begin @(posedge clk); #1; end
        r_pulses = pulses_a - p0;
        r_rdy    = rdy_a - y0;
    endtask

    task automatic load_t1();
        qbuf[0] = 16'd1; qbuf[1] = 16'd2; qbuf[2] = 16'd3;
        rbuf[0] = 16'd5; rbuf[1] = 16'd1; rbuf[2] = 16'd2; rbuf[3] = 16'd3; rbuf[4] = 16'd9;
    endtask

    task automatic check_t1(input string tag);
        chk({tag, "_min"},   64'(r_min),    64'd0);
        chk({tag, "_pos"},   64'(r_pos),    64'd4);
        chk({tag, "_hit"},   64'(r_hit),    64'd1);
        chk({tag, "_err"},   64'(r_err),    64'd0);
        chk({tag, "_pulse"}, 64'(r_pulses), 64'd1);
    endtask

    initial begin
        int guard;
        bit fire;
        int i;
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.qry_len = 8'd0; a_if.ref_len = 32'd0;
        a_if.thresh = 24'd0; a_if.sq_valid = 1'b0; a_if.sq_data = 16'd0;
        a_if.ref_valid = 1'b0; a_if.ref_data = 16'd0;
        b_if.start = 1'b0; b_if.abort = 1'b0; b_if.qry_len = 8'd0; b_if.ref_len = 32'd0;
        b_if.thresh = 16'd0; b_if.sq_valid = 1'b0; b_if.sq_data = 16'd0;
        b_if.ref_valid = 1'b0; b_if.ref_data = 16'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     64'(a_if.busy),      64'd0);
        chk("rst_sq_ready", 64'(a_if.sq_ready),  64'd0);
        chk("rst_ref_rdy",  64'(a_if.ref_ready), 64'd0);
        chk("rst_res_vld",  64'(a_if.res_valid), 64'd0);
        chk("rst_hit",      64'(a_if.hit),       64'd0);
        chk("rst_err",      64'(a_if.err),       64'd0);
        chk("rst_minval",   64'(a_if.minval),    64'hFFFFFF);
        chk("rst_pos",      64'(a_if.position),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_t1();
        run_a(3, 5, 24'd0, 1'b0, -1);
        check_t1("t1");

        qbuf[0] = 16'd2;
        rbuf[0] = 16'd7; rbuf[1] = 16'd4; rbuf[2] = 16'd4;
        run_a(1, 3, 24'd1, 1'b0, -1);
        chk("t2_min",   64'(r_min),    64'd2);
        chk("t2_pos",   64'(r_pos),    64'd2);
        chk("t2_hit",   64'(r_hit),    64'd0);
        chk("t2_pulse", 64'(r_pulses), 64'd1);
        chk("t2_held",  64'(a_if.minval), 64'd2);

        load_t1();
        run_a(3, 5, 24'd0, 1'b1, -1);
        check_t1("t4");

        run_a(3, 5, 24'd0, 1'b0, 2);
        chk("t5_pulse", 64'(r_pulses),      64'd0);
        chk("t5_busy",  64'(a_if.busy),     64'd0);
        chk("t5_min",   64'(a_if.minval),   64'hFFFFFF);
        chk("t5_pos",   64'(a_if.position), 64'd0);
        run_a(3, 5, 24'd0, 1'b0, -1);
        check_t1("t5b");

        run_a(0, 5, 24'hFFFFFF, 1'b0, -1);
        chk("t6a_err", 64'(r_err),          64'd1);
        chk("t6a_min", 64'(r_min),          64'hFFFFFF);
        chk("t6a_pos", 64'(r_pos),          64'd0);
        chk("t6a_hit", 64'(r_hit),          64'd0);
        chk("t6a_lat", 64'(r_lat <= 2),     64'd1);
        chk("t6a_rdy", 64'(r_rdy),          64'd0);
        run_a(251, 5, 24'd0, 1'b0, -1);
        chk("t6b_err",   64'(r_err),        64'd1);
        chk("t6b_min",   64'(r_min),        64'hFFFFFF);
        chk("t6b_lat",   64'(r_lat <= 2),   64'd1);
        chk("t6b_rdy",   64'(r_rdy),        64'd0);
        chk("t6b_pulse", 64'(r_pulses),     64'd1);

        qbuf[0] = 16'd1; qbuf[1] = 16'd2;
        run_a(2, 0, 24'hFFFFFF, 1'b0, -1);
        chk("n0_min", 64'(r_min), 64'hFFFFFF);
        chk("n0_pos", 64'(r_pos), 64'd0);
        chk("n0_hit", 64'(r_hit), 64'd1);
        chk("n0_err", 64'(r_err), 64'd0);
        run_a(2, 0, 24'd5, 1'b0, -1);
        chk("n0_hit_lo", 64'(r_hit), 64'd0);

        b_if.qry_len = 8'd250;
        b_if.ref_len = 32'd10;
        b_if.thresh  = 16'h0100;
        b_if.start   = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        i = 0; guard = 0;
        while (i < 250 && guard < 2000) begin
            b_if.sq_valid = 1'b1;
            b_if.sq_data  = 16'd0;
            fire = b_if.sq_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        b_if.sq_valid = 1'b0;
        i = 0;
        while (i < 10 && guard < 2000) begin
            b_if.ref_valid = 1'b1;
            b_if.ref_data  = 16'hFFFF;
            fire = b_if.ref_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        b_if.ref_valid = 1'b0;
        while (b_if.res_valid !== 1'b1 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("t3_bound", 64'(guard < 3000),   64'd1);
        chk("t3_min",   64'(b_if.minval),    64'hFFFF);
        chk("t3_pos",   64'(b_if.position),  64'd0);
        chk("t3_hit",   64'(b_if.hit),       64'd0);
        chk("t3_err",   64'(b_if.err),       64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
